ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Sequential arbiter that shares the single-port program/data RAM between the CPU's instruction-fetch path, its LOAD/STORE data path and an optional debug/loader port. It sits between the control unit/datapath and the RAM: each requester issues a held request, the arbiter runs one RAM access at a time through a 3-state FSM, and it returns a one-cycle acknowledge with read data. Fixed priority is bounded by a fetch anti-starvation counter.

## Interface
- ADDR_W, 6: RAM address width (64 words).
- DATA_W, 16: word width.
- MAX_WAIT, 4: max consecutive lost arbitrations before fetch is forced to win; legal range 1..15.

- clk  in  1  CPU clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request, read-only, level.
- f_addr  in  ADDR_W  fetch address (PC).
- f_ack  out  1  fetch access complete, 1-cycle pulse.
- f_rdata  out  DATA_W  fetch read data, valid only while f_ack=1.
- d_req  in  1  data request, level.
- d_we  in  1  1 = STORE, 0 = LOAD.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  data access complete, 1-cycle pulse.
- d_rdata  out  DATA_W  load data, valid only while d_ack=1.
- g_req, g_we, g_addr, g_wdata, g_ack, g_rdata: debug port, same widths/semantics as d_*; present only with RAM_ARB_DBG_EN.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data, synchronous read (valid the cycle after address).
- busy  out  1  FSM not in IDLE.
- owner  out  2  current grant: 0 none, 1 fetch, 2 data, 3 debug.

## Operation
- FSM states: IDLE, ACCESS, ACK. Reset state IDLE.
- IDLE: at the clock edge, if any req=1, pick a winner, latch its we/addr/wdata into ram_* registers and set owner -> ACCESS. Otherwise stay in IDLE.
- ACCESS: ram_* are driven from the registers. ram_we = latched we (fetch always 0). The RAM writes/reads on the edge ending ACCESS -> ACK.
- ACK: the owner's ack=1; its rdata = ram_dout (combinational pass-through); all other acks/rdata are 0. The next edge -> IDLE and owner=0.
- Requester rules:
  - Hold req and its fields stable from assertion until the edge that ends its ack cycle.
  - Deassert req on that edge, or keep it high for a back-to-back access.
- Priority: debug > data > fetch. Override: if f_req=1 and wait_cnt==MAX_WAIT, fetch wins.
- wait_cnt (4-bit):
  - +1 on each IDLE decision where f_req=1 and another port wins, saturating at MAX_WAIT.
  - Cleared when fetch is granted, or when f_req=0 in IDLE.
- ram_we=1 only in ACCESS. Outside ACCESS, ram_addr/ram_din hold their last values.
- A STORE also receives an ack; rdata during a STORE ack is don't-care.

## Timing
- Reset values: state IDLE; ram_we, ram_addr, ram_din, all acks, all rdata, busy, owner, wait_cnt = 0.
- Latency: req high in IDLE cycle n -> ACCESS in cycle n+1 -> ack in cycle n+2. Minimum request-to-request spacing is 3 cycles.
- Simultaneous requests: exactly one grant per IDLE decision. Losers keep req high and are considered at the next IDLE.
- A req that rises during ACCESS or ACK is not sampled until the next IDLE.
- Reset mid-access: ram_we, acks and owner drop asynchronously. The in-flight access gets no ack, and the write may or may not have occurred.
- Address wrap: addresses are ADDR_W bits. Callers truncate, and the arbiter performs no range check.

## Configuration
- RAM_ARB_DBG_EN defined: the g_* ports exist, debug has top priority and owner can be 3.
- RAM_ARB_DBG_EN undefined: the g_* ports are absent, arbitration is data > fetch only, and owner never equals 3.

## Structure
- Shared package cpu_mem_pkg holds:
  - the state enum (IDLE/ACCESS/ACK);
  - the owner encoding (OWN_NONE/OWN_FETCH/OWN_DATA/OWN_DBG);
  - defaults for ADDR_W and DATA_W.
- One sub-module, ram_arb_pick: combinational winner select from the req vector, wait_cnt and MAX_WAIT. The FSM, counter and registers stay in ram_arbiter.

## Test plan
- Single fetch: f_req=1, f_addr=5, RAM[5]=0xA123 -> f_ack high exactly in cycle n+2 with f_rdata=0xA123; owner=1 for 2 cycles.
- Store then load: d_we=1, d_addr=10, d_wdata=0x00FF -> ram_we=1 for one cycle, d_ack. Then d_we=0, d_addr=10 -> d_rdata=0x00FF.
- Contention: f_req and d_req rise together -> data acked first. Fetch is acked 3 cycles later with the correct word.
- Starvation, MAX_WAIT=4: f_req held, d_req held continuously -> 4 data acks, then a forced fetch ack, then data resumes.
- Reset mid-ACCESS of a store: rst=0 -> ram_we and d_ack drop immediately, owner=0, state IDLE after release. There is no ack.
- With RAM_ARB_DBG_EN: g_req, d_req and f_req all high -> order debug, data, fetch. Without the macro the bench compiles with no g_* ports.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared FSM state, grant-owner encoding and default widths for the RAM arbiter
package cpu_mem_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2,
    OWN_DBG   = 2'd3
  } owner_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester ports and RAM bus of the RAM arbiter; g_* ports exist only with RAM_ARB_DBG_EN
interface ram_arbiter_if #(
  parameter int ADDR_W = cpu_mem_pkg::ADDR_W_DEF,
  parameter int DATA_W = cpu_mem_pkg::DATA_W_DEF
);
  import cpu_mem_pkg::*;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
`ifdef RAM_ARB_DBG_EN
  logic              g_req;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              g_ack;
  logic [DATA_W-1:0] g_rdata;
`endif
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              busy;
  owner_t            owner;
  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
`ifdef RAM_ARB_DBG_EN
    input  g_req, g_we, g_addr, g_wdata,
    output g_ack, g_rdata,
`endif
    input  ram_dout,
    output f_ack, f_rdata, d_ack, d_rdata, ram_we, ram_addr, ram_din, busy, owner
  );
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
`ifdef RAM_ARB_DBG_EN
    output g_req, g_we, g_addr, g_wdata,
    input  g_ack, g_rdata,
`endif
    output ram_dout,
    input  f_ack, f_rdata, d_ack, d_rdata, ram_we, ram_addr, ram_din, busy, owner
  );
endinterface

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner select, debug > data > fetch unless fetch has waited MAX_WAIT decisions
module ram_arb_pick
  import cpu_mem_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       f_req,
  input  logic       d_req,
  input  logic       g_req,
  input  logic [3:0] wait_cnt,
  output owner_t     winner
);
  always_comb winner = (f_req && wait_cnt == 4'(MAX_WAIT)) ? OWN_FETCH :
                       g_req ? OWN_DBG :
                       d_req ? OWN_DATA :
                       f_req ? OWN_FETCH : OWN_NONE;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: IDLE/ACCESS/ACK sharer of a sync-read RAM between fetch, data and (RAM_ARB_DBG_EN) debug ports
module ram_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);
  state_t            state, state_nxt;
  owner_t            owner_r, winner;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] din_r;
  logic [3:0]        wait_cnt;
  logic              g_req, g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
`ifdef RAM_ARB_DBG_EN
  assign g_req   = bus.g_req;
  assign g_we    = bus.g_we;
  assign g_addr  = bus.g_addr;
  assign g_wdata = bus.g_wdata;
  assign bus.g_ack   = state == ACK && owner_r == OWN_DBG;
  assign bus.g_rdata = bus.g_ack ? bus.ram_dout : '0;
`else
  assign g_req   = 1'b0;
  assign g_we    = 1'b0;
  assign g_addr  = '0;
  assign g_wdata = '0;
`endif
  ram_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
    .f_req   (bus.f_req),
    .d_req   (bus.d_req),
    .g_req   (g_req),
    .wait_cnt(wait_cnt),
    .winner  (winner)
  );
  always_comb begin
    state_nxt = IDLE;
    state_nxt = state == IDLE ? (winner != OWN_NONE ? ACCESS : IDLE) :
                state == ACCESS ? ACK : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // Requests are only sampled in IDLE; the latched copy drives the RAM for the whole access.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      owner_r  <= OWN_NONE;
      we_r     <= 1'b0;
      addr_r   <= '0;
      din_r    <= '0;
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      owner_r  <= winner;
      we_r     <= winner == OWN_DBG ? g_we : winner == OWN_DATA ? bus.d_we : 1'b0;
      if (winner != OWN_NONE)
        addr_r <= winner == OWN_DBG ? g_addr : winner == OWN_DATA ? bus.d_addr : bus.f_addr;
      if (winner == OWN_DBG || winner == OWN_DATA)
        din_r  <= winner == OWN_DBG ? g_wdata : bus.d_wdata;
      wait_cnt <= (!bus.f_req || winner == OWN_FETCH) ? 4'd0 :
                  wait_cnt < 4'(MAX_WAIT) ? wait_cnt + 4'd1 : wait_cnt;
    end else if (state == ACK) begin
      owner_r  <= OWN_NONE;
    end
  assign bus.ram_we   = state == ACCESS && we_r;
  assign bus.ram_addr = addr_r;
  assign bus.ram_din  = din_r;
  assign bus.busy     = state != IDLE;
  assign bus.owner    = owner_r;
  assign bus.f_ack    = state == ACK && owner_r == OWN_FETCH;
  assign bus.f_rdata  = bus.f_ack ? bus.ram_dout : '0;
  assign bus.d_ack    = state == ACK && owner_r == OWN_DATA;
  assign bus.d_rdata  = bus.d_ack ? bus.ram_dout : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed-vector bench for ram_arbiter with a behavioural sync-read RAM
module tb_ram_arbiter;
  import cpu_mem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] mem [64];
  ram_arbiter_if #(.ADDR_W(6), .DATA_W(16)) bus ();
  ram_arbiter #(.ADDR_W(6), .DATA_W(16), .MAX_WAIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic idle_inputs;
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
`ifdef RAM_ARB_DBG_EN
    bus.g_req = 1'b0; bus.g_we = 1'b0; bus.g_addr = '0; bus.g_wdata = '0;
`endif
  endtask

  task automatic test_reset;
    #2;
    vectors++; if (bus.f_ack !== 1'b0) begin miscompares++; $display("FAIL reset_f_ack got %b exp 0", bus.f_ack); end
    vectors++; if (bus.d_ack !== 1'b0) begin miscompares++; $display("FAIL reset_d_ack got %b exp 0", bus.d_ack); end
    vectors++; if (bus.f_rdata !== 16'h0) begin miscompares++; $display("FAIL reset_f_rdata got %h exp 0000", bus.f_rdata); end
    vectors++; if (bus.d_rdata !== 16'h0) begin miscompares++; $display("FAIL reset_d_rdata got %h exp 0000", bus.d_rdata); end
    vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL reset_ram_we got %b exp 0", bus.ram_we); end
    vectors++; if (bus.ram_addr !== 6'd0) begin miscompares++; $display("FAIL reset_ram_addr got %0d exp 0", bus.ram_addr); end
    vectors++; if (bus.ram_din !== 16'h0) begin miscompares++; $display("FAIL reset_ram_din got %h exp 0000", bus.ram_din); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    vectors++; if (bus.owner !== OWN_NONE) begin miscompares++; $display("FAIL reset_owner got %0d exp 0", bus.owner); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch;
    mem[5] <= 16'hA123;
    @(negedge clk); bus.f_req = 1'b1; bus.f_addr = 6'd5;
    @(negedge clk);
    vectors++; if (bus.f_ack !== 1'b0) begin miscompares++; $display("FAIL fetch_n1_ack got %b exp 0", bus.f_ack); end
    vectors++; if (bus.owner !== OWN_FETCH) begin miscompares++; $display("FAIL fetch_n1_owner got %0d exp 1", bus.owner); end
    vectors++; if (bus.ram_addr !== 6'd5) begin miscompares++; $display("FAIL fetch_n1_addr got %0d exp 5", bus.ram_addr); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL fetch_n1_busy got %b exp 1", bus.busy); end
    @(negedge clk);
    vectors++; if (bus.f_ack !== 1'b1) begin miscompares++; $display("FAIL fetch_n2_ack got %b exp 1", bus.f_ack); end
    vectors++; if (bus.f_rdata !== 16'hA123) begin miscompares++; $display("FAIL fetch_n2_rdata got %h exp a123", bus.f_rdata); end
    vectors++; if (bus.owner !== OWN_FETCH) begin miscompares++; $display("FAIL fetch_n2_owner got %0d exp 1", bus.owner); end
    vectors++; if (bus.d_ack !== 1'b0) begin miscompares++; $display("FAIL fetch_n2_d_ack got %b exp 0", bus.d_ack); end
    bus.f_req = 1'b0;
    @(negedge clk);
    vectors++; if (bus.f_ack !== 1'b0) begin miscompares++; $display("FAIL fetch_n3_ack got %b exp 0", bus.f_ack); end
    vectors++; if (bus.owner !== OWN_NONE) begin miscompares++; $display("FAIL fetch_n3_owner got %0d exp 0", bus.owner); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL fetch_n3_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 6'd10; bus.d_wdata = 16'h00FF;
    @(negedge clk);
    vectors++; if (bus.ram_we !== 1'b1) begin miscompares++; $display("FAIL store_ram_we got %b exp 1", bus.ram_we); end
    vectors++; if (bus.ram_addr !== 6'd10) begin miscompares++; $display("FAIL store_ram_addr got %0d exp 10", bus.ram_addr); end
    vectors++; if (bus.ram_din !== 16'h00FF) begin miscompares++; $display("FAIL store_ram_din got %h exp 00ff", bus.ram_din); end
    vectors++; if (bus.d_ack !== 1'b0) begin miscompares++; $display("FAIL store_early_ack got %b exp 0", bus.d_ack); end
    @(negedge clk);
    vectors++; if (bus.d_ack !== 1'b1) begin miscompares++; $display("FAIL store_ack got %b exp 1", bus.d_ack); end
    vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL store_we_in_ack got %b exp 0", bus.ram_we); end
    vectors++; if (mem[10] !== 16'h00FF) begin miscompares++; $display("FAIL store_mem got %h exp 00ff", mem[10]); end
    bus.d_we = 1'b0;
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_busy got %b exp 0", bus.busy); end
    @(negedge clk);
    vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL load_ram_we got %b exp 0", bus.ram_we); end
    vectors++; if (bus.owner !== OWN_DATA) begin miscompares++; $display("FAIL load_owner got %0d exp 2", bus.owner); end
    @(negedge clk);
    vectors++; if (bus.d_ack !== 1'b1) begin miscompares++; $display("FAIL load_ack got %b exp 1", bus.d_ack); end
    vectors++; if (bus.d_rdata !== 16'h00FF) begin miscompares++; $display("FAIL load_rdata got %h exp 00ff", bus.d_rdata); end
    bus.d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention;
    mem[20] <= 16'h1111; mem[21] <= 16'h2222;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd20;
    bus.f_req = 1'b1; bus.f_addr = 6'd21;
    @(negedge clk);
    vectors++; if (bus.owner !== OWN_DATA) begin miscompares++; $display("FAIL cont_first_owner got %0d exp 2", bus.owner); end
    @(negedge clk);
    vectors++; if (bus.d_ack !== 1'b1) begin miscompares++; $display("FAIL cont_d_ack got %b exp 1", bus.d_ack); end
    vectors++; if (bus.d_rdata !== 16'h1111) begin miscompares++; $display("FAIL cont_d_rdata got %h exp 1111", bus.d_rdata); end
    vectors++; if (bus.f_ack !== 1'b0) begin miscompares++; $display("FAIL cont_f_early got %b exp 0", bus.f_ack); end
    bus.d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (bus.owner !== OWN_FETCH) begin miscompares++; $display("FAIL cont_second_owner got %0d exp 1", bus.owner); end
    @(negedge clk);
    vectors++; if (bus.f_ack !== 1'b1) begin miscompares++; $display("FAIL cont_f_ack got %b exp 1", bus.f_ack); end
    vectors++; if (bus.f_rdata !== 16'h2222) begin miscompares++; $display("FAIL cont_f_rdata got %h exp 2222", bus.f_rdata); end
    bus.f_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation;
    owner_t seq [6];
    owner_t exp_seq [6];
    logic [15:0] f_data;
    int n;
    exp_seq = '{OWN_DATA, OWN_DATA, OWN_DATA, OWN_DATA, OWN_FETCH, OWN_DATA};
    n = 0;
    f_data = '0;
    mem[40] <= 16'h4444; mem[41] <= 16'h5555;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd40;
    bus.f_req = 1'b1; bus.f_addr = 6'd41;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk);
      if (bus.d_ack) begin seq[n] = OWN_DATA; n++; end
      else if (bus.f_ack) begin seq[n] = OWN_FETCH; f_data = bus.f_rdata; n++; end
    end
    bus.d_req = 1'b0; bus.f_req = 1'b0;
    vectors++; if (n != 6) begin miscompares++; $display("FAIL starve_ack_count got %0d exp 6", n); end
    for (int i = 0; i < n; i++) begin
      vectors++; if (seq[i] !== exp_seq[i]) begin miscompares++; $display("FAIL starve_order[%0d] got %0d exp %0d", i, seq[i], exp_seq[i]); end
    end
    vectors++; if (f_data !== 16'h5555) begin miscompares++; $display("FAIL starve_f_rdata got %h exp 5555", f_data); end
    for (int c = 0; c < 10 && bus.busy; c++) @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL starve_drain got busy %b exp 0", bus.busy); end
  endtask

  task automatic test_reset_mid_access;
    logic ack_seen;
    @(negedge clk); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 6'd30; bus.d_wdata = 16'hBEEF;
    @(negedge clk);
    vectors++; if (bus.ram_we !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_we got %b exp 1", bus.ram_we); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL rstmid_we got %b exp 0", bus.ram_we); end
    vectors++; if (bus.d_ack !== 1'b0) begin miscompares++; $display("FAIL rstmid_ack got %b exp 0", bus.d_ack); end
    vectors++; if (bus.owner !== OWN_NONE) begin miscompares++; $display("FAIL rstmid_owner got %0d exp 0", bus.owner); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    bus.d_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    ack_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.d_ack || bus.busy) ack_seen = 1'b1;
    end
    vectors++; if (ack_seen !== 1'b0) begin miscompares++; $display("FAIL rstmid_after got activity %b exp 0", ack_seen); end
  endtask

`ifdef RAM_ARB_DBG_EN
  task automatic test_debug_priority;
    owner_t seq [3];
    owner_t exp_seq [3];
    int n;
    exp_seq = '{OWN_DBG, OWN_DATA, OWN_FETCH};
    n = 0;
    mem[50] <= 16'h3333; mem[51] <= 16'h6666; mem[52] <= 16'h9999;
    @(negedge clk);
    bus.g_req = 1'b1; bus.g_we = 1'b0; bus.g_addr = 6'd50;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd51;
    bus.f_req = 1'b1; bus.f_addr = 6'd52;
    for (int c = 0; c < 30 && n < 3; c++) begin
      @(negedge clk);
      if (bus.g_ack) begin seq[n] = OWN_DBG; n++; bus.g_req = 1'b0;
        vectors++; if (bus.g_rdata !== 16'h3333) begin miscompares++; $display("FAIL dbg_g_rdata got %h exp 3333", bus.g_rdata); end
      end else if (bus.d_ack) begin seq[n] = OWN_DATA; n++; bus.d_req = 1'b0;
      end else if (bus.f_ack) begin seq[n] = OWN_FETCH; n++; bus.f_req = 1'b0; end
    end
    idle_inputs();
    vectors++; if (n != 3) begin miscompares++; $display("FAIL dbg_ack_count got %0d exp 3", n); end
    for (int i = 0; i < n; i++) begin
      vectors++; if (seq[i] !== exp_seq[i]) begin miscompares++; $display("FAIL dbg_order[%0d] got %0d exp %0d", i, seq[i], exp_seq[i]); end
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_contention();
    test_starvation();
    test_reset_mid_access();
`ifdef RAM_ARB_DBG_EN
    test_debug_priority();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
